// File: rtl/rf_writeback.sv
// Register-file writeback: arbitrates LSU and ALU results onto the single write port,
// buffers displaced ALU results, and tracks pending writes for RAW/WAW issue stalls.
module rf_writeback #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int ALU_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int PW   = $clog2(ALU_FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_ent_t;

    logic [NREG-1:0] busy, busy_nxt;
    wb_ent_t         fifo_mem [ALU_FIFO_DEPTH];
    logic [PW:0]     wr_ptr, rd_ptr;
    logic            empty, full, alu_acc, push, pop, commit_vld, issue_fire;
    wb_ent_t         commit_ent;

    // Scoreboard lookups; bit 0 is never set so x0 reads as idle.
    assign issue_ready = (issue_rd == '0) || !busy[issue_rd];
    assign rs1_busy    = busy[rs1_addr];
    assign rs2_busy    = busy[rs2_addr];
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

    // Extra pointer bit separates full from empty when the index bits match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign alu_ready = !full;
    assign alu_acc   = alu_valid && alu_ready;

    always_comb begin
        commit_vld = 1'b0;
        commit_ent = '0;
        push       = 1'b0;
        pop        = 1'b0;
        if (lsu_valid) begin
            commit_vld = 1'b1;
            commit_ent = '{rd: lsu_rd, data: lsu_data};
            push       = alu_acc;
        end else if (!empty) begin
            commit_vld = 1'b1;
            commit_ent = fifo_mem[rd_ptr[PW-1:0]];
            pop        = 1'b1;
            push       = alu_acc;
        end else if (alu_acc) begin
            // Empty FIFO: ALU result bypasses straight to the write port.
            commit_vld = 1'b1;
            commit_ent = '{rd: alu_rd, data: alu_data};
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= '{rd: alu_rd, data: alu_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= commit_vld && (commit_ent.rd != '0);
            if (commit_vld) begin
                rf_waddr <= commit_ent.rd;
                rf_wdata <= commit_ent.data;
            end
        end
    end

    // Clear on the RF write edge; a new issue to the same register takes precedence.
    always_comb begin
        busy_nxt = busy;
        if (rf_we)      busy_nxt[rf_waddr] = 1'b0;
        if (issue_fire) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end
endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed vector table, mid-stream reset sequence, and
// random traffic checked against a queue/array reference model.
module tb_rf_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rd, rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rf_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ALU_FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct {
        logic        iv;  logic [4:0] ird, rs1, rs2;
        logic        av;  logic [4:0] ard; logic [31:0] ad;
        logic        lv;  logic [4:0] lrd; logic [31:0] ld;
        logic        e_ir, e_ar, e_b1, e_b2, e_we;
        logic [4:0]  e_wa; logic [31:0] e_wd;
    } vec_t;

    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [4:0] ird, logic [4:0] rs1, logic [4:0] rs2,
                                logic av, logic [4:0] ard, logic [31:0] ad,
                                logic lv, logic [4:0] lrd, logic [31:0] ld,
                                logic ir, logic ar, logic b1, logic b2, logic we,
                                logic [4:0] wa, logic [31:0] wd);
        vec_t v;
        v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.e_ir = ir; v.e_ar = ar; v.e_b1 = b1; v.e_b2 = b2; v.e_we = we; v.e_wa = wa; v.e_wd = wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv; issue_rd = v.ird; rs1_addr = v.rs1; rs2_addr = v.rs2;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
        lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    endtask

    task automatic idle();
        drive(mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    endtask

    // Reference model state: pending-write flags, ALU buffer as a queue, write-port registers.
    logic        m_busy [32];
    ent_t        m_q[$];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_q.delete();
        m_we = 1'b0; m_wa = '0; m_wd = '0;
    endtask

    function automatic logic m_ready(input logic [4:0] rd);
        return (rd == 0) || !m_busy[rd];
    endfunction

    // Applies one clock edge worth of behaviour using the inputs currently driven.
    task automatic model_edge();
        logic        acc, cv, ir;
        ent_t        c;
        acc = alu_valid && (m_q.size() < 2);
        ir  = issue_valid && m_ready(issue_rd);
        cv  = 1'b1;
        c.rd = 0; c.data = 0;
        if (lsu_valid) begin
            c.rd = lsu_rd; c.data = lsu_data;
            if (acc) m_q.push_back('{alu_rd, alu_data});
        end else if (m_q.size() > 0) begin
            c = m_q.pop_front();
            if (acc) m_q.push_back('{alu_rd, alu_data});
        end else if (acc) begin
            c.rd = alu_rd; c.data = alu_data;
        end else begin
            cv = 1'b0;
        end
        if (m_we) m_busy[m_wa] = 1'b0;
        if (ir && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        m_we = cv && (c.rd != 0);
        if (cv) begin m_wa = c.rd; m_wd = c.data; end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #3;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_alu_ready", alu_ready, 1);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Directed table: outputs expected during the cycle the row's inputs are applied.
        tbl.push_back(mk(1,5,5,0, 0,0,0,           0,0,0,      1,1,0,0,0, 0,0));
        tbl.push_back(mk(0,5,5,0, 1,5,32'hDEADBEEF,0,0,0,      0,1,1,0,0, 0,0));
        tbl.push_back(mk(0,0,5,0, 0,0,0,           0,0,0,      1,1,1,0,1, 5,32'hDEADBEEF));
        tbl.push_back(mk(0,0,5,0, 0,0,0,           0,0,0,      1,1,0,0,0, 5,32'hDEADBEEF));
        tbl.push_back(mk(1,7,7,0, 0,0,0,           0,0,0,      1,1,0,0,0, 5,32'hDEADBEEF));
        tbl.push_back(mk(1,7,7,0, 0,0,0,           1,7,32'h77, 0,1,1,0,0, 5,32'hDEADBEEF));
        tbl.push_back(mk(1,7,7,0, 0,0,0,           0,0,0,      0,1,1,0,1, 7,32'h77));
        tbl.push_back(mk(1,7,7,0, 0,0,0,           0,0,0,      1,1,0,0,0, 7,32'h77));
        tbl.push_back(mk(0,0,7,0, 1,4,32'h22,      1,3,32'h11, 1,1,1,0,0, 7,32'h77));
        tbl.push_back(mk(0,0,7,0, 0,0,0,           0,0,0,      1,1,1,0,1, 3,32'h11));
        tbl.push_back(mk(0,0,7,0, 0,0,0,           0,0,0,      1,1,1,0,1, 4,32'h22));
        tbl.push_back(mk(0,0,7,0, 0,0,0,           0,0,0,      1,1,1,0,0, 4,32'h22));
        tbl.push_back(mk(0,0,7,0, 1,9,32'h90,      1,8,32'h80, 1,1,1,0,0, 4,32'h22));
        tbl.push_back(mk(0,0,7,0, 1,11,32'hB0,     1,10,32'hA0,1,1,1,0,1, 8,32'h80));
        tbl.push_back(mk(0,0,7,0, 1,13,32'hD0,     1,12,32'hC0,1,0,1,0,1, 10,32'hA0));
        tbl.push_back(mk(0,0,7,0, 1,13,32'hD0,     1,14,32'hE0,1,0,1,0,1, 12,32'hC0));
        tbl.push_back(mk(0,0,7,0, 1,13,32'hD0,     0,0,0,      1,0,1,0,1, 14,32'hE0));
        tbl.push_back(mk(0,0,7,0, 1,13,32'hD0,     0,0,0,      1,1,1,0,1, 9,32'h90));
        tbl.push_back(mk(0,0,7,0, 0,0,0,           0,0,0,      1,1,1,0,1, 11,32'hB0));
        tbl.push_back(mk(0,0,7,0, 0,0,0,           0,0,0,      1,1,1,0,1, 13,32'hD0));
        tbl.push_back(mk(0,0,7,0, 1,0,32'hFFFFFFFF,0,0,0,      1,1,1,0,0, 13,32'hD0));
        tbl.push_back(mk(0,0,7,0, 0,0,0,           0,0,0,      1,1,1,0,0, 0,32'hFFFFFFFF));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_issue_ready", i), issue_ready, tbl[i].e_ir);
            chk($sformatf("v%0d_alu_ready", i),   alu_ready,   tbl[i].e_ar);
            chk($sformatf("v%0d_rs1_busy", i),    rs1_busy,    tbl[i].e_b1);
            chk($sformatf("v%0d_rs2_busy", i),    rs2_busy,    tbl[i].e_b2);
            chk($sformatf("v%0d_rf_we", i),       rf_we,       tbl[i].e_we);
            chk($sformatf("v%0d_rf_waddr", i),    rf_waddr,    tbl[i].e_wa);
            chk($sformatf("v%0d_rf_wdata", i),    rf_wdata,    tbl[i].e_wd);
            @(posedge clk); #1;
        end

        // Reset mid-stream with a buffered ALU entry, a pending write and busy bits set.
        drive(mk(1,6,0,0, 1,4,32'h2, 1,3,32'h1, 0,0,0,0,0,0,0));
        @(posedge clk); #1;
        drive(mk(0,7,6,7, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        rst = 1'b1;
        #1;
        chk("mid_rst_rf_we", rf_we, 0);
        chk("mid_rst_waddr", rf_waddr, 0);
        chk("mid_rst_wdata", rf_wdata, 0);
        chk("mid_rst_rs1_busy", rs1_busy, 0);
        chk("mid_rst_rs2_busy", rs2_busy, 0);
        chk("mid_rst_alu_ready", alu_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_issue_ready", issue_ready, 1);
        chk("post_rst_alu_ready", alu_ready, 1);
        @(posedge clk); #1;
        chk("post_rst_no_write", rf_we, 0);
        chk("post_rst_waddr", rf_waddr, 0);

        // Random traffic against the reference model; small index range to provoke hazards.
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 31));
            alu_valid   = ($urandom_range(0, 2) != 0);
            alu_rd      = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            lsu_valid   = ($urandom_range(0, 2) == 0);
            lsu_rd      = 5'($urandom_range(0, 7));
            lsu_data    = $urandom;
            #1;
            chk("rnd_issue_ready", issue_ready, m_ready(issue_rd));
            chk("rnd_alu_ready", alu_ready, (m_q.size() < 2));
            chk("rnd_rs1_busy", rs1_busy, m_busy[rs1_addr]);
            chk("rnd_rs2_busy", rs2_busy, m_busy[rs2_addr]);
            chk("rnd_rf_we", rf_we, m_we);
            chk("rnd_rf_waddr", rf_waddr, m_wa);
            chk("rnd_rf_wdata", rf_wdata, m_wd);
            model_edge();
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_writeback.md
# rf_writeback

Writeback/commit unit on the write side of the core's register file. It accepts results from a single-cycle ALU path and from the LSU, arbitrates them onto the single register-file write port, and registers that port's write signals. It also keeps a per-register busy scoreboard so that issue can stall on read-after-write (RAW) and write-after-write (WAW) hazards. It sits between the execute/LSU stages and the register file.

## Interface
- DATA_WIDTH, 32, result/register width
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers, x0 hardwired zero)
- ALU_FIFO_DEPTH, 2, ALU result buffer entries (power of two, ≥2)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  instruction issuing, will write issue_rd
- issue_rd  in  ADDR_WIDTH  destination of issuing instruction
- issue_ready  out  1  issue accepted this cycle
- rs1_addr, rs2_addr  in  ADDR_WIDTH  source indices of instruction at issue
- rs1_busy, rs2_busy  out  1  source has a pending write (combinational)
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted
- alu_rd  in  ADDR_WIDTH  ALU destination
- alu_data  in  DATA_WIDTH  ALU result
- lsu_valid  in  1  load result, always accepted (no ready)
- lsu_rd  in  ADDR_WIDTH  load destination
- lsu_data  in  DATA_WIDTH  load data
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_WIDTH  register-file write address (registered)
- rf_wdata  out  DATA_WIDTH  register-file write data (registered)

## Operation
- Scoreboard: busy[1..31] bits; busy[0] constant 0.
- issue_ready = (issue_rd == 0) || !busy[issue_rd]. This is a WAW stall. A busy bit being cleared on the same edge still stalls; there is no same-cycle forwarding.
- Issue handshake: issue_valid && issue_ready sets busy[issue_rd] at the edge. No bit is set for issue_rd == 0.
- rsN_busy = busy[rsN_addr]. It is 0 for index 0.
- ALU FIFO: an ALU result is accepted when alu_valid && alu_ready. alu_ready = !full. When full, alu_ready stays 0 even if a pop occurs in the same cycle.
- Commit select, one candidate per cycle, in priority order:
  1. lsu_valid: commit the LSU result.
  2. FIFO not empty: commit the FIFO head and pop it.
  3. alu_valid with FIFO empty: the ALU result bypasses the FIFO and is committed directly. It is not pushed.
  4. Otherwise: no commit.
- An ALU result that is accepted but not committed in the same cycle (LSU won) is pushed into the FIFO. An ALU result never both bypasses and pushes.
- Committed entry registers into rf_we=1 (0 if rd==0), rf_waddr=rd, rf_wdata=data. With no commit, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- busy[rf_waddr] clears on the edge where rf_we=1. This is the same edge on which the register file stores the data. Reads in the following cycle see the new value and busy=0.
- A commit to a register that is not busy is still written; the scoreboard is unchanged.
- Continuous lsu_valid starves the ALU path. Once the FIFO is full, alu_ready=0 backpressures execute. This is intended.

## Timing
- Reset (async, immediate): busy all 0; FIFO empty; rf_we=0, rf_waddr=0, rf_wdata=0; alu_ready=1; issue_ready=1 for any issue_rd.
- Reset mid-operation discards FIFO contents and pending busy bits. No write is emitted.
- Latency, result input to rf_we: 1 cycle for LSU or ALU bypass. For a FIFO entry it is 1 cycle after it becomes head and no LSU is present.
- Issue to busy visible on rsN_busy: next cycle.
- Commit (rf_we high) to busy clear: the same edge the register file writes, i.e. 2 edges after the result input.
- Throughput: one register-file write per cycle maximum.
- FIFO pointers wrap modulo ALU_FIFO_DEPTH. Full/empty are distinguished with an extra pointer bit.

## Test plan
- Reset with rst pulsed mid-stream -> rf_we=0 and all rsN_busy=0 within the same cycle; alu_ready=1, issue_ready=1 after release.
- Issue rd=5, then ALU result rd=5, data 0xDEADBEEF -> rs1_busy(5)=1 next cycle; rf_we=1, waddr=5, wdata=0xDEADBEEF one cycle after the result; busy(5)=0 after that edge.
- Issue rd=7 while busy[7]=1 -> issue_ready=0 until the cycle after the rd=7 commit edge. Issue rd=0 -> always ready; rsN_busy(0)=0.
- Simultaneous LSU rd=3 (0x11) and ALU rd=4 (0x22) -> LSU commits first. The ALU entry goes to the FIFO and commits the next cycle.
- Four consecutive cycles of LSU plus ALU -> the FIFO fills after 2 ALU results and alu_ready=0. When the LSU stops, the FIFO drains in order, one commit per cycle, then alu_ready=1.
- ALU result to rd=0 with data 0xFFFFFFFF -> rf_we stays 0 and the handshake completes (alu_ready unaffected).
